// File: rtl/clut_pkg.sv
// Shared types, default geometry and the grey-ramp entry generator for the banked CLUT.
package clut_pkg;

    localparam int unsigned DEF_COLOR_BITS = 4;
    localparam int unsigned DEF_LINE_SIZE  = 3;
    localparam int unsigned DEF_INDEX_BITS = 4;
    localparam int unsigned DEF_NUM_BANKS  = 4;
    localparam int unsigned DEF_BANK_BITS  = 2;

    localparam int unsigned NUM_OF_COLORS = 2 ** DEF_INDEX_BITS;
    localparam int unsigned ENTRY_W       = DEF_COLOR_BITS * DEF_LINE_SIZE;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } clut_state_e;

    // Every channel carries the index, zero-extended or truncated to the channel width.
    function automatic logic [63:0] grey_entry(input logic [31:0] index,
                                               input int unsigned color_bits,
                                               input int unsigned line_size);
        logic [63:0] e;
        e = '0;
        for (int unsigned c = 0; c < line_size; c++) begin
            for (int unsigned b = 0; b < color_bits; b++) begin
                if ((c * color_bits + b) < 64 && b < 32)
                    e[6'(c * color_bits + b)] = index[5'(b)];
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/clut_ram.sv
// Simple dual-port palette storage: one write port, one registered read-first read port.
module clut_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read share the edge; the read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/clut_banked.sv
// Multi-bank colour look-up table: grey-ramp init sequencer, req/ack write port,
// frame-synchronous bank switch and a two-stage pixel lookup pipeline.
module clut_banked #(
    parameter int unsigned COLOR_BITS = clut_pkg::DEF_COLOR_BITS,
    parameter int unsigned LINE_SIZE  = clut_pkg::DEF_LINE_SIZE,
    parameter int unsigned INDEX_BITS = clut_pkg::DEF_INDEX_BITS,
    parameter int unsigned NUM_BANKS  = clut_pkg::DEF_NUM_BANKS,
    parameter int unsigned BANK_BITS  = clut_pkg::DEF_BANK_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            pix_valid,
    input  logic [INDEX_BITS-1:0]           pix_index,
    output logic                            out_valid,
    output logic [COLOR_BITS*LINE_SIZE-1:0] out_rgb,
    input  logic                            frame_start,
    input  logic [BANK_BITS-1:0]            disp_bank_sel,
    output logic [BANK_BITS-1:0]            active_bank,
    input  logic                            wr_req,
    input  logic [BANK_BITS-1:0]            wr_bank,
    input  logic [INDEX_BITS-1:0]           wr_addr,
    input  logic [COLOR_BITS*LINE_SIZE-1:0] wr_data,
    output logic                            wr_ack,
    output logic                            init_busy
);

    import clut_pkg::*;

    localparam int unsigned N_COLORS = 1 << INDEX_BITS;
    localparam int unsigned DATA_W   = COLOR_BITS * LINE_SIZE;
    localparam int unsigned ADDR_W   = BANK_BITS + INDEX_BITS;
    localparam int unsigned DEPTH    = NUM_BANKS * N_COLORS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clut_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic               ram_we_c;
    logic [ADDR_W-1:0]  ram_waddr_c;
    logic [DATA_W-1:0]  ram_wdata_c;
    logic [ADDR_W-1:0]  ram_raddr_c;
    logic [DATA_W-1:0]  rd_data;
    logic               pix_v1_q;
    logic               pix_init1_q;

    assign ram_raddr_c = {active_bank, pix_index};

    clut_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .waddr (ram_waddr_c),
        .wdata (ram_wdata_c),
        .raddr (ram_raddr_c),
        .rdata (rd_data)
    );

    // Next-state and write-port steering: ramp fill, then one CPU write per two cycles.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = init_cnt_q;
        ram_wdata_c = DATA_W'(grey_entry(32'(init_cnt_q[INDEX_BITS-1:0]), COLOR_BITS, LINE_SIZE));
        case (state_q)
            ST_INIT: begin
                ram_we_c = 1'b1;
                if (init_cnt_q == LAST_ADDR)
                    state_d = ST_IDLE;
                else
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
            end
            ST_IDLE: begin
                if (wr_req) begin
                    ram_we_c    = 1'b1;
                    ram_waddr_c = {wr_bank, wr_addr};
                    ram_wdata_c = wr_data;
                    state_d     = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Control registers: FSM state, init counter, handshake/status outputs, displayed bank.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wr_ack      <= 1'b0;
            init_busy   <= 1'b1;
            active_bank <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_ack     <= (state_d == ST_ACK);
            init_busy  <= (state_d == ST_INIT);
            if (frame_start)
                active_bank <= disp_bank_sel;
        end
    end

    // Pixel pipeline: valid and init flag track the RAM read, output holds when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_v1_q    <= 1'b0;
            pix_init1_q <= 1'b0;
            out_valid   <= 1'b0;
            out_rgb     <= '0;
        end else begin
            pix_v1_q    <= pix_valid;
            pix_init1_q <= (state_q == ST_INIT);
            out_valid   <= pix_v1_q;
            if (pix_v1_q)
                out_rgb <= pix_init1_q ? '0 : rd_data;
        end
    end

endmodule

// File: tb/tb_clut_banked.sv
// Directed bench for clut_banked with a palette-level reference model checked every cycle.
module tb_clut_banked;

    import clut_pkg::*;

    localparam int unsigned NB = DEF_NUM_BANKS;
    localparam int unsigned NC = NUM_OF_COLORS;
    localparam int unsigned INIT_CYCLES = NB * NC;

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         pix_valid;
    logic [DEF_INDEX_BITS-1:0]    pix_index;
    logic                         out_valid;
    logic [ENTRY_W-1:0]           out_rgb;
    logic                         frame_start;
    logic [DEF_BANK_BITS-1:0]     disp_bank_sel;
    logic [DEF_BANK_BITS-1:0]     active_bank;
    logic                         wr_req;
    logic [DEF_BANK_BITS-1:0]     wr_bank;
    logic [DEF_INDEX_BITS-1:0]    wr_addr;
    logic [ENTRY_W-1:0]           wr_data;
    logic                         wr_ack;
    logic                         init_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    clut_banked dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pix_valid     (pix_valid),
        .pix_index     (pix_index),
        .out_valid     (out_valid),
        .out_rgb       (out_rgb),
        .frame_start   (frame_start),
        .disp_bank_sel (disp_bank_sel),
        .active_bank   (active_bank),
        .wr_req        (wr_req),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .init_busy     (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: palette contents, displayed bank, init countdown, handshake phase.
    logic [ENTRY_W-1:0] m_mem [NB][NC];
    int                 m_init_left = 0;
    int unsigned        m_active = 0;
    bit                 m_ack = 1'b0;
    bit                 m_s1_v = 1'b0;
    logic [ENTRY_W-1:0] m_s1_val = '0;
    bit                 m_out_v = 1'b0;
    logic [ENTRY_W-1:0] m_out_rgb = '0;

    always @(posedge clk) begin
        bit was_init;
        bit accept;
        logic [3:0] n;
        if (!reset_n) begin
            m_init_left = INIT_CYCLES;
            m_active    = 0;
            m_ack       = 1'b0;
            m_s1_v      = 1'b0;
            m_out_v     = 1'b0;
            m_out_rgb   = '0;
        end else begin
            was_init = (m_init_left > 0);
            m_out_v = m_s1_v;
            if (m_s1_v)
                m_out_rgb = m_s1_val;
            m_s1_v   = pix_valid;
            m_s1_val = was_init ? '0 : m_mem[m_active][pix_index];
            accept = !was_init && !m_ack && wr_req;
            if (accept)
                m_mem[wr_bank][wr_addr] = wr_data;
            m_ack = accept;
            if (frame_start)
                m_active = disp_bank_sel;
            if (was_init) begin
                m_init_left--;
                if (m_init_left == 0)
                    for (int b = 0; b < NB; b++)
                        for (int i = 0; i < NC; i++) begin
                            n = 4'(i);
                            m_mem[b][i] = {n, n, n};
                        end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(m_out_v));
            chk("cyc_out_rgb", 32'(out_rgb), 32'(m_out_rgb));
            chk("cyc_active_bank", 32'(active_bank), m_active);
            chk("cyc_wr_ack", 32'(wr_ack), 32'(m_ack));
            chk("cyc_init_busy", 32'(init_busy), 32'(m_init_left > 0));
        end
    end

    task automatic lookup(input int idx, input logic [ENTRY_W-1:0] exp, input string name);
        pix_valid = 1'b1;
        pix_index = DEF_INDEX_BITS'(idx);
        @(negedge clk);
        pix_valid = 1'b0;
        chk({name, "_valid_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_rgb"}, 32'(out_rgb), 32'(exp));
    endtask

    task automatic frame(input int sel);
        frame_start   = 1'b1;
        disp_bank_sel = DEF_BANK_BITS'(sel);
        @(negedge clk);
        frame_start = 1'b0;
        chk("frame_active", 32'(active_bank), 32'(sel));
    endtask

    task automatic do_write(input int b, input int a, input logic [ENTRY_W-1:0] d, output int lat);
        wr_req  = 1'b1;
        wr_bank = DEF_BANK_BITS'(b);
        wr_addr = DEF_INDEX_BITS'(a);
        wr_data = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wr_ack && lat < 200);
        wr_req = 1'b0;
        chk("write_ack_seen", 32'(wr_ack), 32'd1);
    endtask

    task automatic count_init(input string name);
        int cnt;
        cnt = 0;
        while (init_busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, INIT_CYCLES);
    endtask

    initial begin
        int lat;
        int waited;
        bit acked_busy;
        reset_n = 1'b0; pix_valid = 1'b0; pix_index = '0; frame_start = 1'b0;
        disp_bank_sel = '0; wr_req = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rgb", 32'(out_rgb), 32'd0);
        chk("rst_active", 32'(active_bank), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_init_busy", 32'(init_busy), 32'd1);
        started = 1'b1;
        reset_n = 1'b1;
        count_init("init_len");
        lookup(5, 12'h555, "ramp5");

        // Write handshake, then display the written bank.
        do_write(2, 3, 12'hABC, lat);
        chk("ack_latency", lat, 1);
        @(negedge clk);
        chk("ack_one_cycle", 32'(wr_ack), 32'd0);
        frame(2);
        lookup(3, 12'hABC, "bank2_wr");

        // Bank switch timing on a continuous pixel stream.
        do_write(1, 7, 12'h123, lat);
        @(negedge clk);
        frame(0);
        pix_valid = 1'b1; pix_index = 4'd7; frame_start = 1'b1; disp_bank_sel = 2'd1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("switch_old_valid", 32'(out_valid), 32'd1);
        chk("switch_old_rgb", 32'(out_rgb), 32'h777);
        @(negedge clk);
        chk("switch_new_valid", 32'(out_valid), 32'd1);
        chk("switch_new_rgb", 32'(out_rgb), 32'h123);

        // Same-cycle write and lookup of one entry is read-first.
        frame(0);
        wr_req = 1'b1; wr_bank = 2'd0; wr_addr = 4'd9; wr_data = 12'hF00;
        pix_valid = 1'b1; pix_index = 4'd9;
        @(negedge clk);
        chk("coll_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        @(negedge clk);
        pix_valid = 1'b0;
        chk("coll_old_rgb", 32'(out_rgb), 32'h999);
        @(negedge clk);
        chk("coll_new_rgb", 32'(out_rgb), 32'hF00);

        // Write requested during INIT is held off and lands after the ramp.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        wr_req = 1'b1; wr_bank = 2'd3; wr_addr = 4'd1; wr_data = 12'h5A5;
        lookup(4, 12'h000, "init_pix");
        frame(1);
        acked_busy = 1'b0;
        waited = 0;
        while (!wr_ack && waited < 200) begin
            @(negedge clk);
            waited++;
            if (wr_ack && init_busy)
                acked_busy = 1'b1;
        end
        wr_req = 1'b0;
        chk("init_wr_ack_seen", 32'(wr_ack), 32'd1);
        chk("init_wr_ack_after_busy", 32'(acked_busy), 32'd0);
        @(negedge clk);
        frame(3);
        lookup(1, 12'h5A5, "init_wr_land");

        // Reset in the middle of INIT restarts the full fill.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(init_busy), 32'd1);
        reset_n = 1'b1;
        count_init("midrst_init_len");
        lookup(15, 12'hFFF, "ramp15");
        lookup(9, 12'h999, "ramp9_refill");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clut_banked.md
Name: clut_banked

Overview:
Multi-bank colour look-up table for the video path. It holds NUM_BANKS palettes of NUM_OF_COLORS entries, each entry LINE_SIZE channels of COLOR_BITS. The pixel pipeline reads it on the pixel side, and a CPU/loader port writes it through a req/ack handshake. The displayed bank switches only on frame boundaries. After reset, an internal sequencer fills every bank with a grey ramp, replacing the file-loaded palette of the previous generation.

Parameters:
COLOR_BITS, 4, bits per colour channel
LINE_SIZE, 3, channels per entry (r, g, b)
INDEX_BITS, 4, palette index width; NUM_OF_COLORS = 2**INDEX_BITS (derived localparam)
NUM_BANKS, 4, palette banks, power of two, >= 2
BANK_BITS, 2, log2(NUM_BANKS)

Ports:
clk  in  1  single clock, all logic posedge
reset_n  in  1  synchronous reset, active-low
pix_valid  in  1  pixel index valid this cycle
pix_index  in  INDEX_BITS  palette index to look up
out_valid  out  1  out_rgb valid, pix_valid delayed 2 cycles
out_rgb  out  COLOR_BITS*LINE_SIZE  looked-up colour, channel 0 in LSBs
frame_start  in  1  one-cycle pulse at start of vblank
disp_bank_sel  in  BANK_BITS  bank to display from next frame
active_bank  out  BANK_BITS  bank currently used for lookups
wr_req  in  1  write request, level, held until wr_ack
wr_bank  in  BANK_BITS  target bank
wr_addr  in  INDEX_BITS  target entry
wr_data  in  COLOR_BITS*LINE_SIZE  entry data
wr_ack  out  1  one-cycle pulse, write committed
init_busy  out  1  grey-ramp fill in progress

Behaviour:
- Reset (reset_n low at posedge): out_valid=0, out_rgb=0, active_bank=0, wr_ack=0, init_busy=1, FSM->INIT with init counter=0. Asserting reset during INIT or a pending write restarts INIT. RAM contents are not cleared by reset itself; INIT overwrites every entry.
- Storage: one array of NUM_BANKS*NUM_OF_COLORS words, addressed {bank, index}, with one write port and one read port per cycle.
- FSM states:
  - INIT: writes one entry per cycle, counter 0..NUM_BANKS*NUM_OF_COLORS-1. Entry value: every channel = index zero-extended/truncated to COLOR_BITS. After the last write, go to IDLE with init_busy=0. INIT lasts exactly NUM_BANKS*NUM_OF_COLORS cycles after reset deasserts.
  - IDLE: if wr_req=1, write {wr_bank,wr_addr}<=wr_data this cycle, go to ACK.
  - ACK: wr_ack=1 for this single cycle, return to IDLE. wr_req is ignored in ACK. The requester drops or updates wr_req on seeing wr_ack. Maximum sustained rate is 1 write per 2 cycles.
  - wr_req during INIT is held off with no ack until IDLE.
- Pixel path is a 2-stage pipeline:
  - Cycle N: pix_valid/pix_index sampled, RAM read at {active_bank, pix_index}.
  - Cycle N+1: read data registered.
  - Cycle N+2: out_rgb/out_valid registered.
  - When out_valid=0, out_rgb holds its last value.
  - During INIT, out_valid still follows pix_valid, but out_rgb is forced to 0.
- Read/write collision on the same address in the same cycle is read-first: the lookup returns the old entry, and the new value is visible to reads from the next cycle.
- Bank switch: on frame_start=1, active_bank<=disp_bank_sel, effective for lookups sampled in the following cycle. A pixel sampled in the frame_start cycle uses the old bank. disp_bank_sel is ignored when frame_start=0. frame_start during INIT still updates active_bank.
- Writes to active_bank are allowed and take effect mid-frame; double-buffering is the software's job (write a non-displayed bank, then switch).
- All index/bank arithmetic is unsigned. The init counter wraps only by leaving INIT.

Decomposition:
- Shared package clut_pkg holds:
  - FSM state encoding (INIT, IDLE, ACK).
  - localparams NUM_OF_COLORS and ENTRY_W = COLOR_BITS*LINE_SIZE.
  - The grey-ramp entry function.
- One sub-module: clut_ram. Simple dual-port, one clock, registered read, read-first, no initial block.
- FSM, bank register and output stage live in clut_banked.

Test Plan:
- Reset then INIT, default params: init_busy high for exactly 64 cycles. Afterwards, lookup index 5 in bank 0 -> out_rgb=12'h555 with out_valid exactly 2 cycles after pix_valid.
- Write handshake: wr_req with bank 2, addr 3, data 12'hABC in IDLE -> wr_ack one cycle later for one cycle. Then set disp_bank_sel=2, pulse frame_start, and look up index 3 -> 12'hABC.
- Bank switch timing: pixel stream with bank0[7]=12'h777 and bank1[7]=12'h123, frame_start with disp_bank_sel=1. The pixel in the pulse cycle -> 12'h777; the next pixel -> 12'h123.
- Collision: write bank0 addr 9 = 12'hF00 in the same cycle as a lookup of bank0 idx 9 -> 12'h999. The lookup one cycle later -> 12'hF00.
- Write during INIT: wr_req held from cycle 10 after reset -> no wr_ack until init_busy falls, and the write lands afterwards (not overwritten by the ramp). Pixels during INIT give out_rgb=0.
- Reset mid-INIT at cycle 30 -> init_busy stays high, and the full 64-cycle INIT restarts from counter 0.
